// File: rtl/blockmem_2p_arb.sv
// blockmem_2p_arb: two-requester round-robin front end for one simple dual-port RAM.
// Optional same-address write-to-read forwarding is enabled by defining BLOCKMEM_ARB_BYPASS_EN.
module blockmem_2p_arb #(
    parameter int G_DATAWIDTH = 32,
    parameter int G_MEMDEPTH  = 1024,
    parameter int G_ADDRWIDTH = $clog2(G_MEMDEPTH),
    parameter int G_BWENABLE  = 0,
    parameter int G_WEWIDTH   = (((((G_DATAWIDTH + 7) & ~7) - 1) / 8) * G_BWENABLE) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               wr_valid,
    output logic [1:0]               wr_ready,
    input  logic [2*G_ADDRWIDTH-1:0] wr_addr,
    input  logic [2*G_DATAWIDTH-1:0] wr_data,
    input  logic [2*G_WEWIDTH-1:0]   wr_strb,
    input  logic [1:0]               rd_valid,
    output logic [1:0]               rd_ready,
    input  logic [2*G_ADDRWIDTH-1:0] rd_addr,
    output logic [1:0]               rsp_valid,
    input  logic [1:0]               rsp_ready,
    output logic [2*G_DATAWIDTH-1:0] rsp_data,
    output logic                     mem_ena,
    output logic [G_WEWIDTH-1:0]     mem_wea,
    output logic [G_ADDRWIDTH-1:0]   mem_addra,
    output logic [G_DATAWIDTH-1:0]   mem_dina,
    output logic                     mem_enb,
    output logic [G_ADDRWIDTH-1:0]   mem_addrb,
    input  logic [G_DATAWIDTH-1:0]   mem_doutb
);

    function automatic logic in_range(input logic [G_ADDRWIDTH-1:0] a);
        return 32'(a) < 32'(G_MEMDEPTH);
    endfunction

    logic                     wr_pri_q, wr_pri_d;
    logic [1:0]               wr_grant;
    logic                     wr_sel;
    logic [G_ADDRWIDTH-1:0]   wr_addr_sel;
    logic                     mem_ena_q, mem_ena_d;
    logic [G_WEWIDTH-1:0]     mem_wea_q, mem_wea_d;
    logic [G_ADDRWIDTH-1:0]   mem_addra_q, mem_addra_d;
    logic [G_DATAWIDTH-1:0]   mem_dina_q, mem_dina_d;

    logic                     rd_pri_q, rd_pri_d;
    logic [1:0]               rd_elig, rd_grant;
    logic                     rd_sel;
    logic [G_ADDRWIDTH-1:0]   rd_addr_sel;
    logic [1:0]               busy_q, busy_d;
    logic                     mem_enb_q, mem_enb_d;
    logic [G_ADDRWIDTH-1:0]   mem_addrb_q, mem_addrb_d;
    logic                     s1_valid_q, s1_valid_d, s1_req_q, s1_req_d, s1_oor_q, s1_oor_d;
    logic                     s2_valid_q, s2_req_q, s2_oor_q;
    logic [1:0]               rsp_valid_q, rsp_valid_d;
    logic [2*G_DATAWIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [G_DATAWIDTH-1:0]   rd_word;

    // Write side: pri_q names the requester that wins a tie.
    always_comb begin
        wr_grant = 2'b00;
        if (!rst) begin
            if (wr_valid == 2'b11) wr_grant[wr_pri_q] = 1'b1;
            else                   wr_grant = wr_valid;
        end
        wr_sel      = wr_grant[1];
        wr_addr_sel = wr_sel ? wr_addr[G_ADDRWIDTH +: G_ADDRWIDTH] : wr_addr[0 +: G_ADDRWIDTH];
        wr_pri_d    = (|wr_grant) ? ~wr_sel : wr_pri_q;
        mem_ena_d   = (|wr_grant) && in_range(wr_addr_sel);
        mem_wea_d   = '0;
        if (mem_ena_d) mem_wea_d = wr_sel ? wr_strb[G_WEWIDTH +: G_WEWIDTH] : wr_strb[0 +: G_WEWIDTH];
        mem_addra_d = (|wr_grant) ? wr_addr_sel : mem_addra_q;
        mem_dina_d  = mem_dina_q;
        if (|wr_grant) mem_dina_d = wr_sel ? wr_data[G_DATAWIDTH +: G_DATAWIDTH] : wr_data[0 +: G_DATAWIDTH];
    end

    always_comb begin
        rd_elig  = rd_valid & ~busy_q & {2{~rst}};
        rd_grant = 2'b00;
        if (rd_elig == 2'b11) rd_grant[rd_pri_q] = 1'b1;
        else                  rd_grant = rd_elig;
        rd_sel      = rd_grant[1];
        rd_addr_sel = rd_sel ? rd_addr[G_ADDRWIDTH +: G_ADDRWIDTH] : rd_addr[0 +: G_ADDRWIDTH];
        rd_pri_d    = (|rd_grant) ? ~rd_sel : rd_pri_q;
        // Out-of-range reads skip the RAM and answer zero on the normal schedule.
        mem_enb_d   = (|rd_grant) && in_range(rd_addr_sel);
        mem_addrb_d = (|rd_grant) ? rd_addr_sel : mem_addrb_q;
        s1_valid_d  = |rd_grant;
        s1_req_d    = rd_sel;
        s1_oor_d    = !in_range(rd_addr_sel);
        busy_d      = (busy_q | rd_grant) & ~(rsp_valid_q & rsp_ready);
    end

`ifdef BLOCKMEM_ARB_BYPASS_EN
    logic                   coll_q, coll_d;
    logic [G_WEWIDTH-1:0]   coll_wea_q;
    logic [G_DATAWIDTH-1:0] coll_din_q;
    logic [G_DATAWIDTH-1:0] coll_mask;

    for (genvar gi = 0; gi < G_DATAWIDTH; gi++) begin : g_coll_mask
        assign coll_mask[gi] = coll_wea_q[(G_BWENABLE != 0) ? gi / 8 : 0];
    end

    always_comb begin
        coll_d  = mem_ena_q && mem_enb_q && (mem_addra_q == mem_addrb_q);
        rd_word = coll_q ? ((coll_din_q & coll_mask) | (mem_doutb & ~coll_mask)) : mem_doutb;
        if (s2_oor_q) rd_word = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            coll_q     <= 1'b0;
            coll_wea_q <= '0;
            coll_din_q <= '0;
        end else begin
            coll_q     <= coll_d;
            coll_wea_q <= mem_wea_q;
            coll_din_q <= mem_dina_q;
        end
    end
`else
    always_comb begin
        rd_word = s2_oor_q ? '0 : mem_doutb;
    end
`endif

    // Responses stay put until consumed; a new capture only lands on an idle slot.
    always_comb begin
        rsp_valid_d = rsp_valid_q & ~rsp_ready;
        rsp_data_d  = rsp_data_q;
        if (s2_valid_q) begin
            rsp_valid_d[s2_req_q] = 1'b1;
            if (s2_req_q) rsp_data_d[G_DATAWIDTH +: G_DATAWIDTH] = rd_word;
            else          rsp_data_d[0 +: G_DATAWIDTH]           = rd_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_pri_q    <= 1'b0;
            mem_ena_q   <= 1'b0;
            mem_wea_q   <= '0;
            mem_addra_q <= '0;
            mem_dina_q  <= '0;
            rd_pri_q    <= 1'b0;
            busy_q      <= 2'b00;
            mem_enb_q   <= 1'b0;
            mem_addrb_q <= '0;
            s1_valid_q  <= 1'b0;
            s1_req_q    <= 1'b0;
            s1_oor_q    <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_req_q    <= 1'b0;
            s2_oor_q    <= 1'b0;
            rsp_valid_q <= 2'b00;
            rsp_data_q  <= '0;
        end else begin
            wr_pri_q    <= wr_pri_d;
            mem_ena_q   <= mem_ena_d;
            mem_wea_q   <= mem_wea_d;
            mem_addra_q <= mem_addra_d;
            mem_dina_q  <= mem_dina_d;
            rd_pri_q    <= rd_pri_d;
            busy_q      <= busy_d;
            mem_enb_q   <= mem_enb_d;
            mem_addrb_q <= mem_addrb_d;
            s1_valid_q  <= s1_valid_d;
            s1_req_q    <= s1_req_d;
            s1_oor_q    <= s1_oor_d;
            s2_valid_q  <= s1_valid_q;
            s2_req_q    <= s1_req_q;
            s2_oor_q    <= s1_oor_q;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign wr_ready  = wr_grant;
    assign rd_ready  = rd_grant;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign mem_ena   = mem_ena_q;
    assign mem_wea   = mem_wea_q;
    assign mem_addra = mem_addra_q;
    assign mem_dina  = mem_dina_q;
    assign mem_enb   = mem_enb_q;
    assign mem_addrb = mem_addrb_q;

endmodule

// File: tb/tb_blockmem_2p_arb.sv
// Directed bench for blockmem_2p_arb with a read-first RAM model; depth 1000 exercises range checks.
module tb_blockmem_2p_arb;
    localparam int DW  = 32;
    localparam int AW  = 10;
    localparam int WEW = 1;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      wr_valid, wr_ready, rd_valid, rd_ready, rsp_valid, rsp_ready;
    logic [2*AW-1:0] wr_addr, rd_addr;
    logic [2*DW-1:0] wr_data, rsp_data;
    logic [2*WEW-1:0] wr_strb;
    logic            mem_ena, mem_enb;
    logic [WEW-1:0]  mem_wea;
    logic [AW-1:0]   mem_addra, mem_addrb;
    logic [DW-1:0]   mem_dina, mem_doutb;
    logic [DW-1:0]   ram [1024] = '{default: '0};
    int              tests = 0;
    int              fails = 0;

`ifdef BLOCKMEM_ARB_BYPASS_EN
    localparam logic [DW-1:0] CollExp = 32'h1111_1111;
`else
    localparam logic [DW-1:0] CollExp = 32'h0000_0000;
`endif

    blockmem_2p_arb #(
        .G_DATAWIDTH(DW),
        .G_MEMDEPTH (1000)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_strb  (wr_strb),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_addr  (rd_addr),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data (rsp_data),
        .mem_ena  (mem_ena),
        .mem_wea  (mem_wea),
        .mem_addra(mem_addra),
        .mem_dina (mem_dina),
        .mem_enb  (mem_enb),
        .mem_addrb(mem_addrb),
        .mem_doutb(mem_doutb)
    );

    always #5 clk = ~clk;

    // Read-first RAM: port B sees the old word when port A writes the same address.
    always @(posedge clk) begin
        if (mem_enb) mem_doutb <= ram[mem_addrb];
        if (mem_ena && mem_wea[0]) ram[mem_addra] <= mem_dina;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; wr_valid = '0; rd_valid = '0; rsp_ready = '0;
        wr_addr = '0; rd_addr = '0; wr_data = '0; wr_strb = '0;
        step(); step();
        wr_valid = 2'b11;
        #1;
        chk("rst_wr_ready", 64'(wr_ready), 64'(0));
        chk("rst_ctrl", 64'({mem_ena, mem_enb, mem_wea, rsp_valid, rd_ready}), 64'(0));
        chk("rst_addr", 64'({mem_addra, mem_addrb}), 64'(0));
        chk("rst_data", 64'(mem_dina), 64'(0));
        chk("rst_rsp_data", rsp_data, 64'(0));
        wr_valid = 2'b00;
        rst = 1'b0;
        step();
        #1;
        chk("idle_ctrl", 64'({mem_ena, mem_enb, mem_wea, rsp_valid, wr_ready, rd_ready}), 64'(0));

        // Both writers held valid: grants alternate starting with requester 0.
        wr_addr = {10'd11, 10'd10}; wr_data = {32'hB1B1_B1B1, 32'hA0A0_A0A0};
        wr_strb = 2'b11; wr_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("wr_rr_ready", 64'(wr_ready), 64'((i % 2 == 0) ? 2'b01 : 2'b10));
            chk("wr_rr_ena", 64'(mem_ena), 64'(i > 0));
            if (i > 0) chk("wr_rr_addra", 64'(mem_addra), 64'((i % 2 == 1) ? 10 : 11));
            step();
        end
        wr_valid = 2'b00;
        #1;
        chk("wr_rr_last_addra", 64'(mem_addra), 64'(11));
        chk("wr_rr_last_dina", 64'(mem_dina), 64'(32'hB1B1_B1B1));
        step();
        #1;
        chk("wr_idle_ena", 64'({mem_ena, mem_wea}), 64'(0));

        // Requester 0 writes DEADBEEF to 5, then reads it back.
        wr_valid = 2'b01; wr_addr[9:0] = 10'd5; wr_data[31:0] = 32'hDEAD_BEEF; wr_strb = 2'b01;
        #1;
        chk("wr0_ready", 64'(wr_ready), 64'(2'b01));
        step();
        wr_valid = 2'b00;
        #1;
        chk("wr0_mem", 64'({mem_ena, mem_wea, mem_addra}), 64'({1'b1, 1'b1, 10'd5}));
        chk("wr0_dina", 64'(mem_dina), 64'(32'hDEAD_BEEF));
        step();
        rd_valid = 2'b01; rd_addr[9:0] = 10'd5;
        #1;
        chk("rd0_ready", 64'(rd_ready), 64'(2'b01));
        step();
        rd_valid = 2'b00;
        #1;
        chk("rd0_memb", 64'({mem_enb, mem_addrb}), 64'({1'b1, 10'd5}));
        chk("rd0_t1_valid", 64'(rsp_valid), 64'(0));
        step();
        #1;
        chk("rd0_t2_valid", 64'(rsp_valid), 64'(0));
        step();
        #1;
        chk("rd0_t3_valid", 64'(rsp_valid), 64'(2'b01));
        chk("rd0_t3_data", 64'(rsp_data[31:0]), 64'(32'hDEAD_BEEF));
        rsp_ready = 2'b01;
        step();
        rsp_ready = 2'b00;
        #1;
        chk("rd0_consumed", 64'(rsp_valid), 64'(0));

        // Requester 1 stalls its response while requester 0 keeps reading.
        rsp_ready = 2'b01; rd_valid = 2'b10; rd_addr = {10'd11, 10'd10};
        #1;
        chk("rd1_ready", 64'(rd_ready), 64'(2'b10));
        step();
        rd_valid = 2'b11;
        for (int k = 1; k <= 12; k++) begin
            #1;
            chk("stall_rd_ready", 64'(rd_ready), 64'((k % 4 == 1) ? 2'b01 : 2'b00));
            chk("stall_rsp1_valid", 64'(rsp_valid[1]), 64'(k >= 3));
            if (k >= 3) chk("stall_rsp1_data", 64'(rsp_data[63:32]), 64'(32'hB1B1_B1B1));
            chk("stall_rsp0_valid", 64'(rsp_valid[0]), 64'(k % 4 == 0));
            if (k % 4 == 0) chk("stall_rsp0_data", 64'(rsp_data[31:0]), 64'(32'hA0A0_A0A0));
            step();
        end
        rd_valid = 2'b00; rsp_ready = 2'b10;
        #1;
        chk("release_rsp_valid", 64'(rsp_valid), 64'(2'b10));
        step();
        rd_valid = 2'b10; rd_addr[19:10] = 10'd5;
        #1;
        chk("after_hs_valid", 64'(rsp_valid), 64'(0));
        chk("after_hs_ready", 64'(rd_ready), 64'(2'b10));
        step();
        rd_valid = 2'b00;
        step(); step();
        #1;
        chk("rd1_again_valid", 64'(rsp_valid), 64'(2'b10));
        chk("rd1_again_data", 64'(rsp_data[63:32]), 64'(32'hDEAD_BEEF));
        step();
        #1;
        chk("rd1_again_done", 64'(rsp_valid), 64'(0));

        // Same-cycle write and read of address 7 (old value 0).
        wr_valid = 2'b01; wr_addr[9:0] = 10'd7; wr_data[31:0] = 32'h1111_1111; wr_strb = 2'b01;
        rd_valid = 2'b10; rd_addr[19:10] = 10'd7;
        #1;
        chk("coll_ready", 64'({wr_ready, rd_ready}), 64'(4'b0110));
        step();
        wr_valid = 2'b00; rd_valid = 2'b00;
        #1;
        chk("coll_mem", 64'({mem_ena, mem_enb, mem_addra, mem_addrb}), 64'({2'b11, 10'd7, 10'd7}));
        step(); step();
        #1;
        chk("coll_valid", 64'(rsp_valid), 64'(2'b10));
        chk("coll_data", 64'(rsp_data[63:32]), 64'(CollExp));
        step();
        rsp_ready = 2'b01; rd_valid = 2'b01; rd_addr[9:0] = 10'd7;
        #1;
        chk("coll_done", 64'(rsp_valid), 64'(0));
        chk("readback_ready", 64'(rd_ready), 64'(2'b01));
        step();
        rd_valid = 2'b00;
        step(); step();
        #1;
        chk("readback_data", 64'({rsp_valid, rsp_data[31:0]}), 64'({2'b01, 32'h1111_1111}));
        step();

        // Reset one cycle after a read accept drops the read.
        rd_valid = 2'b01; rd_addr[9:0] = 10'd5;
        #1;
        chk("rstmid_ready", 64'(rd_ready), 64'(2'b01));
        step();
        rd_valid = 2'b00; rst = 1'b1;
        step();
        rst = 1'b0; rd_valid = 2'b01; rd_addr[9:0] = 10'd10;
        #1;
        chk("rstmid_cleared", 64'({mem_enb, rsp_valid}), 64'(0));
        chk("rstmid_next_ready", 64'(rd_ready), 64'(2'b01));
        step();
        rd_valid = 2'b00;
        #1;
        chk("rstmid_t3_valid", 64'(rsp_valid), 64'(0));
        step();
        #1;
        chk("rstmid_t4_valid", 64'(rsp_valid), 64'(0));
        step();
        #1;
        chk("rstmid_new_rsp", 64'({rsp_valid, rsp_data[31:0]}), 64'({2'b01, 32'hA0A0_A0A0}));
        step();

        // Address 1005 lies beyond the 1000-word RAM.
        rsp_ready = 2'b00;
        wr_valid = 2'b10; wr_addr[19:10] = 10'd1005; wr_data[63:32] = 32'hCAFE_F00D; wr_strb = 2'b10;
        #1;
        chk("oor_wr_ready", 64'(wr_ready), 64'(2'b10));
        step();
        wr_valid = 2'b00;
        #1;
        chk("oor_wr_ena", 64'({mem_ena, mem_wea}), 64'(0));
        step();
        rd_valid = 2'b01; rd_addr[9:0] = 10'd1005;
        #1;
        chk("oor_rd_ready", 64'(rd_ready), 64'(2'b01));
        step();
        rd_valid = 2'b00;
        #1;
        chk("oor_ena_idle", 64'(mem_ena), 64'(0));
        step();
        #1;
        chk("oor_t2_valid", 64'(rsp_valid), 64'(0));
        step();
        #1;
        chk("oor_rsp", 64'({rsp_valid, rsp_data[31:0]}), 64'({2'b01, 32'h0}));
        rsp_ready = 2'b01;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/blockmem_2p_arb.md
Name: blockmem_2p_arb

Overview:
- Two-requester arbiter/sequencer in front of one blockmem_2p instance (write port A, read port B, same clock on both).
- Each requester has a valid/ready write channel and a read request/response channel, with round-robin arbitration per port.
- Memory-side outputs are registered, and read responses are buffered per requester with backpressure.
- Feeds the AXI front-end so two masters can share one simple dual-port RAM.

Parameters:
- G_DATAWIDTH, 32, data width of RAM and requesters
- G_MEMDEPTH, 1024, RAM words
- G_ADDRWIDTH, $clog2(G_MEMDEPTH), word address width
- G_BWENABLE, 0, 1 = byte write strobes honoured; 0 = strobe bit 0 used for whole word
- G_WEWIDTH, (((((G_DATAWIDTH+7)&~7)-1)/8)*G_BWENABLE)+1, strobe width (matches blockmem_2p)

Ports:
- clk  in  1  single clock for arbiter and both RAM ports
- rst  in  1  synchronous reset, active-high
- wr_valid  in  2  per-requester write request (bit r = requester r)
- wr_ready  out  2  write accepted this cycle
- wr_addr  in  2*G_ADDRWIDTH  write address, requester r at [r*G_ADDRWIDTH+:G_ADDRWIDTH]
- wr_data  in  2*G_DATAWIDTH  write data
- wr_strb  in  2*G_WEWIDTH  write strobes
- rd_valid  in  2  read request
- rd_ready  out  2  read request accepted
- rd_addr  in  2*G_ADDRWIDTH  read address
- rsp_valid  out  2  read response available
- rsp_ready  in  2  response consumed
- rsp_data  out  2*G_DATAWIDTH  read response data
- mem_ena  out  1  RAM port A enable
- mem_wea  out  G_WEWIDTH  RAM write enable
- mem_addra  out  G_ADDRWIDTH  RAM write address
- mem_dina  out  G_DATAWIDTH  RAM write data
- mem_enb  out  1  RAM port B enable
- mem_addrb  out  G_ADDRWIDTH  RAM read address
- mem_doutb  in  G_DATAWIDTH  RAM read data; valid the cycle after mem_enb

Behaviour:
- Reset values:
  - wr_ready, rd_ready, rsp_valid, mem_ena, mem_enb, mem_wea: 0.
  - mem_addra, mem_addrb, mem_dina, rsp_data: 0.
  - Both round-robin pointers favour requester 0 first.
  - busy flags cleared.
- Write arbitration:
  - wr_ready is combinational from wr_valid and the write pointer; at most one bit set per cycle.
  - If both requesters are valid, the one not granted last wins. If one is valid, it wins. The pointer updates only on a grant.
  - Accept at cycle T registers mem_ena=1, mem_wea=strb, mem_addra, mem_dina for cycle T+1; otherwise mem_ena=0, mem_wea=0.
  - A requester writing on consecutive cycles alone gets a grant every cycle (full throughput).
- Read arbitration:
  - rd_ready[r] = rd_valid[r] & ~busy[r] & round-robin winner among eligible requesters (separate pointer).
  - Accept at T sets busy[r] and drives mem_enb=1, mem_addrb for T+1.
  - mem_doutb is captured at the end of T+2 into rsp_data[r]; rsp_valid[r] is asserted from T+3.
  - rsp_valid and rsp_data are held stable until rsp_ready; busy[r] clears on rsp_valid&rsp_ready. The next read from r can be accepted the cycle after the handshake.
  - Requester 0 and 1 reads may be interleaved back-to-back; each requester has at most one read outstanding.
- Address range: if G_MEMDEPTH is not a power of two, addr ≥ G_MEMDEPTH:
  - writes are accepted but mem_ena stays 0 (dropped);
  - reads are accepted, and rsp_data returns all zero with normal timing.
- Same-address collision: a read and a write reaching the RAM in the same cycle to the same address return old data (RAM read-first), unless the optional feature below is enabled.
- Reset mid-operation: in-flight reads are discarded, no rsp_valid is produced, and pending memory enables are cleared on the next edge.

Optional Feature:
- Macro: BLOCKMEM_ARB_BYPASS_EN.
- Defined:
  - Register a collision flag and the write strobes/data when mem_enb and mem_ena coincide with mem_addra==mem_addrb.
  - On capture, bytes with strobe set take the new write data, while other bytes take mem_doutb (whole word when G_BWENABLE=0).
- Undefined: no bypass logic; collision returns pre-write data.

Test Plan:
- Reset then idle: all outputs 0. wr_valid=2'b11 held: wr_ready alternates 01,10,01,… and mem_ena=1 every cycle from the second cycle.
- Requester 0 writes 0xDEADBEEF to addr 5, then reads addr 5: rsp_valid[0] rises exactly 3 cycles after rd accept with rsp_data=0xDEADBEEF.
- Requester 1 read with rsp_ready=0 for 10 cycles: rsp_data held constant, rd_ready[1]=0 while busy, and requester 0 reads continue to be served.
- Same-cycle accept: write 0x11111111 to addr 7 (old value 0x0) and read addr 7. Without BLOCKMEM_ARB_BYPASS_EN the response is 0x00000000; with it, the response is 0x11111111 (G_BWENABLE=1, strb=4'b0011: 0x00001111).
- Assert rst one cycle after a read accept: no rsp_valid follows, busy cleared, and the next read is accepted immediately.
- G_MEMDEPTH=1000, write and read addr 1005: mem_ena stays 0, and the response is 0x00000000 with normal 3-cycle latency.
